regfile_dump: RTL and testbench
===============================

# regfile_dump

Sequential reader for the integer register file. On a start pulse it walks a contiguous, wrap-around range of register addresses through one combinational read port and streams each (address, data) pair out over a valid/ready interface. It is used for debug readout, context save and end-of-test register checks, and sits beside the core on a spare read port of the register file.

## Interface
- DATA_N, 32, register data width
- SIZE, 32, number of registers; address width fixed at 5 bits, addresses wrap modulo 32
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a dump; sampled only in IDLE
- first_addr  in  5  first register of the range; sampled with start
- last_addr  in  5  final register of the range; sampled with start
- rd_addr  out  5  register file read address
- rd_data  in  DATA_N  register file read data, combinational from rd_addr
- out_valid  out  1  output beat present
- out_ready  in  1  consumer accepts the beat this cycle
- out_addr  out  5  register index of the current beat
- out_data  out  DATA_N  register value of the current beat
- out_last  out  1  current beat is the final one of the dump
- busy  out  1  dump in progress (RUN or DRAIN)
- done  out  1  one-cycle pulse after the final beat is accepted

## Operation
- States: IDLE, RUN, DRAIN.
- Internal: ptr (5b), remaining (6b, range 1..32).
- IDLE: start=1 latches ptr<=first_addr, remaining<=((last_addr-first_addr) mod 32)+1, moves to RUN. first_addr==last_addr gives 1 beat; last_addr==first_addr-1 (mod 32) gives 32 beats.
- rd_addr = ptr at all times.
- Load condition in RUN: !out_valid || out_ready.
- On load: out_data<=rd_data, out_addr<=ptr, out_valid<=1, out_last<=(remaining==1), ptr<=ptr+1 (mod 32), remaining<=remaining-1. If remaining==1, go to DRAIN.
- RUN with out_valid && !out_ready: hold all outputs and ptr; no beat dropped or duplicated.
- DRAIN: on out_valid && out_ready, out_valid<=0, out_last<=0, done<=1 for one cycle, go to IDLE.
- busy = (state != IDLE).
- start while busy is ignored. start in the same cycle as done is accepted.
- Data is captured at the load edge. A register file write at that same edge is not reflected; the pre-write value is captured.
- x0 is read like any other register; the value comes from the file (0).
- Reset, including mid-dump: state IDLE, ptr 0, remaining 0, rd_addr 0, out_valid 0, out_addr 0, out_data 0, out_last 0, busy 0, done 0. No done pulse for an aborted dump.

## Timing
- start sampled at edge k: busy=1 from edge k.
- First beat valid from edge k+1.
- With out_ready held high, beats appear on consecutive cycles, i.e. throughput is 1 beat per cycle.
- N-beat dump with out_ready held high: beats valid from edge k+1 through edge k+N. done=1 and busy=0 from edge k+N+1 for exactly one cycle.
- Each stall cycle (out_valid && !out_ready) delays all later events by one cycle.
- Output registers change only at a load edge, at reset, or at the DRAIN accept edge.

## Test plan
- Full dump. Preload regs[i]=i*3 with regs[11]=5, first=0, last=31, out_ready=1. Required: 32 beats, addr 0..31 with matching data (beat 11 = 5), out_last only on addr 31, done exactly one cycle at k+33.
- Single beat. first=last=11. Required: one beat addr 11, data 5, out_last=1, done one cycle after acceptance.
- Wrap. first=30, last=1. Required: beats addr 30, 31, 0, 1 in order, out_last on addr 1. Also first=5, last=4 yields 32 beats ending at addr 4.
- Backpressure. out_ready pattern 1,0,0,1,0,1… over a 6-beat dump. Required: out_addr/out_data stable while stalled, exactly 6 accepted beats in order, done only after the 6th acceptance.
- Start while busy. Pulse start again mid-dump with a different range. Required: ignored, original sequence unaffected.
- Reset mid-dump. Assert rst after 3 accepted beats. Required: all outputs 0 immediately (asynchronous), no done; a new start afterwards runs a correct dump.

Source files
------------

// File: rtl/regfile_dump.sv
// regfile_dump: walks a wrap-around register range through one read port and
// streams (addr, data) beats over valid/ready.
module regfile_dump #(
  parameter int DATA_N = 32,
  parameter int SIZE   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        first_addr,
  input  logic [4:0]        last_addr,
  output logic [4:0]        rd_addr,
  input  logic [DATA_N-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_addr,
  output logic [DATA_N-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  localparam int RW = $clog2(SIZE) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t        state;
  logic [4:0]    ptr;
  logic [4:0]    span;
  logic [RW-1:0] remaining;
  logic          load;
  // span wraps mod 32, so last == first-1 yields a full 32-beat dump
  assign span    = last_addr - first_addr;
  assign load    = (state == RUN) && (!out_valid || out_ready);
  assign rd_addr = ptr;
  assign busy    = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        ptr       <= first_addr;
        remaining <= RW'(span) + RW'(1);
        state     <= RUN;
      end
      if (load) begin
        out_data  <= rd_data;
        out_addr  <= ptr;
        out_valid <= 1'b1;
        out_last  <= remaining == RW'(1);
        ptr       <= ptr + 5'd1;
        remaining <= remaining - RW'(1);
        if (remaining == RW'(1)) state <= DRAIN;
      end
      if (state == DRAIN && out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        done      <= 1'b1;
        state     <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed tests for regfile_dump against a hand-built register file.
module tb_regfile_dump;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  first_addr = '0;
  logic [4:0]  last_addr = '0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] regs [32];
  logic [4:0]  got_addr [$];
  logic [31:0] got_data [$];
  logic        got_last [$];
  int          done_cyc, stall_bad;
  logic        busy_seen;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  regfile_dump #(.DATA_N(32), .SIZE(32)) dut (
    .clk(clk), .rst(rst), .start(start), .first_addr(first_addr), .last_addr(last_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  assign rd_data = regs[rd_addr];
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_data(input int a);
    return (a == 11) ? 32'd5 : 32'(a * 3);
  endfunction

  // Starts a dump from a negedge and records accepted beats; returns at the
  // negedge where done is seen. done_cyc = c means done is high after edge k+c.
  task automatic do_dump(input logic [4:0] f, input logic [4:0] l, input bit bp, input bit inject);
    bit         pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bit         held = 1'b0;
    logic [4:0] h_addr = '0;
    logic [31:0] h_data = '0;
    got_addr.delete();
    got_data.delete();
    got_last.delete();
    done_cyc = 0;
    stall_bad = 0;
    first_addr = f;
    last_addr = l;
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    busy_seen = busy;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (held && (out_addr !== h_addr || out_data !== h_data || out_valid !== 1'b1)) stall_bad++;
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
      if (inject) begin
        start = (c == 3);
        first_addr = 5'd20;
        last_addr = 5'd25;
      end
      out_ready = bp ? pat[(c - 1) % 6] : 1'b1;
      if (out_valid && out_ready) begin
        got_addr.push_back(out_addr);
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      held = out_valid && !out_ready;
      h_addr = out_addr;
      h_data = out_data;
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if ({out_valid, out_last, busy, done} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {out_valid, out_last, busy, done});
    else pass_cnt++;
    total_cnt++;
    if (out_addr !== 5'd0 || out_data !== 32'd0 || rd_addr !== 5'd0)
      $display("FAIL reset_regs got addr=%0d data=%0h rd_addr=%0d want 0", out_addr, out_data, rd_addr);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_full;
    do_dump(5'd0, 5'd31, 1'b0, 1'b0);
    total_cnt++;
    if (busy_seen !== 1'b1) $display("FAIL full_busy got %b want 1", busy_seen);
    else pass_cnt++;
    total_cnt++;
    if (got_addr.size() != 32) $display("FAIL full_count got %0d want 32", got_addr.size());
    else pass_cnt++;
    for (int i = 0; i < got_addr.size() && i < 32; i++) begin
      total_cnt++;
      if (got_addr[i] !== 5'(i) || got_data[i] !== exp_data(i) || got_last[i] !== (i == 31))
        $display("FAIL full_beat%0d got addr=%0d data=%0d last=%b want addr=%0d data=%0d last=%b",
                 i, got_addr[i], got_data[i], got_last[i], i, exp_data(i), i == 31);
      else pass_cnt++;
    end
    total_cnt++;
    if (done_cyc != 33) $display("FAIL full_done_cycle got %0d want 33", done_cyc);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL full_busy_at_done got %b want 0", busy);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL full_done_width got done=%b busy=%b want 0 0", done, busy);
    else pass_cnt++;
  endtask

  task automatic test_single;
    do_dump(5'd11, 5'd11, 1'b0, 1'b0);
    total_cnt++;
    if (got_addr.size() != 1) $display("FAIL single_count got %0d want 1", got_addr.size());
    else pass_cnt++;
    total_cnt++;
    if (got_addr.size() < 1 || got_addr[0] !== 5'd11 || got_data[0] !== 32'd5 || got_last[0] !== 1'b1)
      $display("FAIL single_beat got size=%0d want addr=11 data=5 last=1", got_addr.size());
    else pass_cnt++;
    total_cnt++;
    if (done_cyc != 2) $display("FAIL single_done_cycle got %0d want 2", done_cyc);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_wrap;
    logic [4:0] e [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
    do_dump(5'd30, 5'd1, 1'b0, 1'b0);
    total_cnt++;
    if (got_addr.size() != 4) $display("FAIL wrap_count got %0d want 4", got_addr.size());
    else pass_cnt++;
    for (int i = 0; i < got_addr.size() && i < 4; i++) begin
      total_cnt++;
      if (got_addr[i] !== e[i] || got_data[i] !== exp_data(int'(e[i])) || got_last[i] !== (i == 3))
        $display("FAIL wrap_beat%0d got addr=%0d data=%0d last=%b want addr=%0d data=%0d last=%b",
                 i, got_addr[i], got_data[i], got_last[i], e[i], exp_data(int'(e[i])), i == 3);
      else pass_cnt++;
    end
    total_cnt++;
    if (done_cyc != 5) $display("FAIL wrap_done_cycle got %0d want 5", done_cyc);
    else pass_cnt++;
    @(negedge clk);
  endtask

  // first=5, last=4 is a full 32-beat dump; the next dump starts in the done cycle
  task automatic test_back_to_back;
    int bad = 0;
    do_dump(5'd5, 5'd4, 1'b0, 1'b0);
    total_cnt++;
    if (got_addr.size() != 32 || done_cyc != 33) $display("FAIL wrap32_count got %0d beats done@%0d want 32 done@33", got_addr.size(), done_cyc);
    else pass_cnt++;
    for (int i = 0; i < got_addr.size() && i < 32; i++)
      if (got_addr[i] !== 5'((i + 5) % 32) || got_data[i] !== exp_data((i + 5) % 32) || got_last[i] !== (i == 31)) bad++;
    total_cnt++;
    if (bad != 0) $display("FAIL wrap32_beats got %0d bad beats want 0", bad);
    else pass_cnt++;
    do_dump(5'd2, 5'd3, 1'b0, 1'b0);
    total_cnt++;
    if (got_addr.size() != 2 || got_addr[0] !== 5'd2 || got_addr[1] !== 5'd3 || done_cyc != 3)
      $display("FAIL b2b_second got %0d beats done@%0d want 2 beats (2,3) done@3", got_addr.size(), done_cyc);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    do_dump(5'd9, 5'd14, 1'b1, 1'b0);
    total_cnt++;
    if (got_addr.size() != 6) $display("FAIL bp_count got %0d want 6", got_addr.size());
    else pass_cnt++;
    for (int i = 0; i < got_addr.size() && i < 6; i++) begin
      total_cnt++;
      if (got_addr[i] !== 5'(9 + i) || got_data[i] !== exp_data(9 + i) || got_last[i] !== (i == 5))
        $display("FAIL bp_beat%0d got addr=%0d data=%0d last=%b want addr=%0d data=%0d last=%b",
                 i, got_addr[i], got_data[i], got_last[i], 9 + i, exp_data(9 + i), i == 5);
      else pass_cnt++;
    end
    total_cnt++;
    if (stall_bad != 0) $display("FAIL bp_stall_hold got %0d changes want 0", stall_bad);
    else pass_cnt++;
    total_cnt++;
    if (done_cyc != 13) $display("FAIL bp_done_cycle got %0d want 13", done_cyc);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_start_busy;
    do_dump(5'd0, 5'd5, 1'b0, 1'b1);
    total_cnt++;
    if (got_addr.size() != 6 || done_cyc != 7) $display("FAIL busy_start_count got %0d beats done@%0d want 6 done@7", got_addr.size(), done_cyc);
    else pass_cnt++;
    for (int i = 0; i < got_addr.size() && i < 6; i++) begin
      total_cnt++;
      if (got_addr[i] !== 5'(i) || got_data[i] !== exp_data(i))
        $display("FAIL busy_start_beat%0d got addr=%0d data=%0d want addr=%0d data=%0d", i, got_addr[i], got_data[i], i, exp_data(i));
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL busy_start_idle got busy=%b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    first_addr = 5'd8;
    last_addr = 5'd20;
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b1 || out_addr !== 5'd11) $display("FAIL rstmid_pre got valid=%b addr=%0d want 1 11", out_valid, out_addr);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({out_valid, out_last, busy, done} !== 4'b0 || out_addr !== 5'd0 || out_data !== 32'd0 || rd_addr !== 5'd0)
      $display("FAIL rstmid_async got valid=%b last=%b busy=%b done=%b addr=%0d data=%0h rd_addr=%0d want all 0",
               out_valid, out_last, busy, done, out_addr, out_data, rd_addr);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL rstmid_no_done got %0d bad cycles want 0", bad);
    else pass_cnt++;
    do_dump(5'd2, 5'd4, 1'b0, 1'b0);
    total_cnt++;
    if (got_addr.size() != 3 || got_addr[0] !== 5'd2 || got_addr[2] !== 5'd4 || got_data[1] !== 32'd9 || done_cyc != 4)
      $display("FAIL rstmid_restart got %0d beats done@%0d want 3 beats 2..4 done@4", got_addr.size(), done_cyc);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = exp_data(i);
    test_reset();
    test_full();
    test_single();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
